// File: rtl/mux_n_in_reg.sv
// rtl/mux_n_in_reg.sv - N-way channel select feeding a 2-entry valid/ready output buffer
// Optional feature macro MUX_ERROR_SEL_EN: out-of-range Sel stores zero and sets sticky Error_sel.
module mux_n_in_reg #(
  parameter int  ANCHO      = 32,
  parameter int  N_ENTRADAS = 4,
  localparam int SEL_ANCHO  = (N_ENTRADAS > 2) ? $clog2(N_ENTRADAS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [N_ENTRADAS*ANCHO-1:0] Datos,
  input  logic [SEL_ANCHO-1:0]        Sel,
  input  logic                        Valido_in,
  output logic                        Listo,
  output logic [ANCHO-1:0]            Salida,
  output logic                        Valido_out,
  input  logic                        Listo_in
`ifdef MUX_ERROR_SEL_EN
  ,
  output logic                        Error_sel
`endif
);

  logic [1:0]       cnt_q, cnt_d;
  logic [ANCHO-1:0] head_q, head_d;
  logic [ANCHO-1:0] tail_q, tail_d;
  logic [ANCHO-1:0] sel_word;
  logic             sel_oor;
  logic             push, pop;

  always_comb begin
    sel_word = Datos[ANCHO-1:0];
    sel_oor  = 1'b1;
    for (int i = 0; i < N_ENTRADAS; i++) begin
      if (int'(Sel) == i) begin
        sel_word = Datos[i*ANCHO +: ANCHO];
        sel_oor  = 1'b0;
      end
    end
`ifdef MUX_ERROR_SEL_EN
    if (sel_oor) sel_word = '0;
`else
    // Out-of-range select falls back to channel 0.
    if (sel_oor) sel_word = Datos[ANCHO-1:0];
`endif
  end

  // Listo depends only on the occupancy register, never on Listo_in.
  assign Listo      = (cnt_q != 2'd2);
  assign Valido_out = (cnt_q != 2'd0);
  assign Salida     = head_q;
  assign push       = Valido_in && Listo;
  assign pop        = Valido_out && Listo_in;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = sel_word;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = sel_word;
        end else if (push) begin
          tail_d = sel_word;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef MUX_ERROR_SEL_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push & sel_oor);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign Error_sel = err_q;
`endif

endmodule

// File: tb/tb_mux_n_in_reg.sv
// tb/tb_mux_n_in_reg.sv - queue-model bench for a 4-channel and a 3-channel mux_n_in_reg
module tb_mux_n_in_reg;

  logic         Clk;
  logic         Reset_n;

  logic [127:0] datos_a;
  logic [1:0]   sel_a;
  logic         vin_a, lin_a, listo_a, vout_a;
  logic [31:0]  salida_a;

  logic [95:0]  datos_b;
  logic [1:0]   sel_b;
  logic         vin_b, lin_b, listo_b, vout_b;
  logic [31:0]  salida_b;

`ifdef MUX_ERROR_SEL_EN
  logic         err_a, err_b;
`endif

  mux_n_in_reg #(.ANCHO(32), .N_ENTRADAS(4)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Datos(datos_a), .Sel(sel_a),
    .Valido_in(vin_a), .Listo(listo_a), .Salida(salida_a),
    .Valido_out(vout_a), .Listo_in(lin_a)
`ifdef MUX_ERROR_SEL_EN
    , .Error_sel(err_a)
`endif
  );

  mux_n_in_reg #(.ANCHO(32), .N_ENTRADAS(3)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Datos(datos_b), .Sel(sel_b),
    .Valido_in(vin_b), .Listo(listo_b), .Salida(salida_b),
    .Valido_out(vout_b), .Listo_in(lin_b)
`ifdef MUX_ERROR_SEL_EN
    , .Error_sel(err_b)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          exp_err_b;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word the buffer should capture for the 3-channel build.
  function automatic logic [31:0] word_b(input logic [1:0] s, input logic [95:0] d);
    int si;
    si = int'(s);
    if (si < 3) return d[si*32 +: 32];
`ifdef MUX_ERROR_SEL_EN
    return 32'd0;
`else
    return d[31:0];
`endif
  endfunction

  task automatic check_outputs();
    chk_eq("listo_a", {31'd0, listo_a}, {31'd0, qa.size() != 2});
    chk_eq("vout_a",  {31'd0, vout_a},  {31'd0, qa.size() != 0});
    if (qa.size() > 0) chk_eq("salida_a", salida_a, qa[0]);
    chk_eq("listo_b", {31'd0, listo_b}, {31'd0, qb.size() != 2});
    chk_eq("vout_b",  {31'd0, vout_b},  {31'd0, qb.size() != 0});
    if (qb.size() > 0) chk_eq("salida_b", salida_b, qb[0]);
`ifdef MUX_ERROR_SEL_EN
    chk_eq("err_a", {31'd0, err_a}, 32'd0);
    chk_eq("err_b", {31'd0, err_b}, {31'd0, exp_err_b});
`endif
  endtask

  task automatic cycle(input logic va, input logic [1:0] sa, input logic la,
                       input logic vb, input logic [1:0] sb, input logic lb);
    bit          pa, oa, pb, ob;
    logic [31:0] wa, wb;
    vin_a = va; sel_a = sa; lin_a = la;
    vin_b = vb; sel_b = sb; lin_b = lb;
    pa = va && (qa.size() < 2);
    oa = la && (qa.size() > 0);
    pb = vb && (qb.size() < 2);
    ob = lb && (qb.size() > 0);
    wa = datos_a[int'(sa)*32 +: 32];
    wb = word_b(sb, datos_b);
    @(posedge Clk);
    #1;
    if (oa) void'(qa.pop_front());
    if (pa) qa.push_back(wa);
    if (ob) void'(qb.pop_front());
    if (pb) qb.push_back(wb);
    if (pb && sb >= 2'd3) exp_err_b = 1'b1;
    check_outputs();
  endtask

  initial begin
    Reset_n = 1'b0;
    datos_a = {32'd8, 32'd6, 32'd4, 32'd2};
    datos_b = {32'd6, 32'd4, 32'd2};
    sel_a = '0; sel_b = '0;
    vin_a = 1'b0; vin_b = 1'b0; lin_a = 1'b0; lin_b = 1'b0;
    exp_err_b = 1'b0;
    #2;
    chk_eq("rst_salida_a", salida_a, 32'd0);
    chk_eq("rst_salida_b", salida_b, 32'd0);
    check_outputs();
    #10 Reset_n = 1'b1;

    // Back-to-back selects 0..3 with the consumer always ready.
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 1'b1, 1'b1, 2'(i), 1'b1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Back-pressure: two pushes fill the buffer, then drain.
    cycle(1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0);
    cycle(1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Async reset mid-cycle with both buffers full.
    cycle(1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0);
    cycle(1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 1'b0);
    #3 Reset_n = 1'b0;
    #1;
    qa.delete(); qb.delete(); exp_err_b = 1'b0;
    chk_eq("arst_salida_a", salida_a, 32'd0);
    chk_eq("arst_salida_b", salida_b, 32'd0);
    check_outputs();
    #1 Reset_n = 1'b1;
    cycle(1'b1, 2'd3, 1'b0, 1'b1, 2'd2, 1'b0);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Randomized traffic with fresh channel data every cycle.
    for (int n = 0; n < 3000; n++) begin
      datos_a = {$urandom, $urandom, $urandom, $urandom};
      datos_b = {$urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
